// File: rtl/serializer_8b.sv
// Parallel-in, serial-out transmitter: accepts an 8-bit word on a valid/ready
// handshake and emits it MSB first, one bit per output beat.
module serializer_8b (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic [7:0] in_data,
    output logic       out_val,
    input  logic       out_rdy,
    output logic       out_bit,
    output logic       out_last
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state_reg;
    logic [7:0] shreg_reg;
    logic [2:0] cnt_reg;
    logic [7:0] shift_next;
    logic       last_beat;
    logic       in_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shift_next[gi] = 1'b0;
            end else begin : g_upper
                assign shift_next[gi] = shreg_reg[gi-1];
            end
        end
    endgenerate

    assign last_beat = (state_reg == SHIFT) && (cnt_reg == 3'd7);

    // in_rdy looks through to out_rdy on the last beat so words can abut.
    assign in_rdy   = !rst && ((state_reg == IDLE) || (last_beat && out_rdy));
    assign in_xfer  = in_val && in_rdy;
    assign out_val  = !rst && (state_reg == SHIFT);
    assign out_bit  = (state_reg == SHIFT) && shreg_reg[7];
    assign out_last = last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            shreg_reg <= 8'h00;
            cnt_reg   <= 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_xfer) begin
                        shreg_reg <= in_data;
                        cnt_reg   <= 3'd0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_rdy) begin
                        if (cnt_reg != 3'd7) begin
                            shreg_reg <= shift_next;
                            cnt_reg   <= cnt_reg + 3'd1;
                        end else if (in_val) begin
                            shreg_reg <= in_data;
                            cnt_reg   <= 3'd0;
                        end else begin
                            state_reg <= IDLE;
                            cnt_reg   <= 3'd0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= 3'd0;
                end
            endcase
        end
    end

endmodule
